// File: rtl/dram_ctrl_pkg.sv
// Shared types and defaults for the DRAM access controller.
// Optional perf counters use the saturating increment below (DRAM_ACCESS_PERF_CNT_EN).
package dram_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    SAVE  = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin against the last winner, or fixed priority to P0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       rr_mode,
  output logic [1:0] gnt
);

  // rr_last = 0 means P0 won last, so P1 takes a conflict in round-robin mode
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (rr_mode && !rr_last) gnt = 2'b10;
        else                     gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_access_ctrl.sv
// Session sequencer (load/run/save) and P0/P1 access arbiter for the image DRAM.
// Define DRAM_ACCESS_PERF_CNT_EN to add saturating per-requester grant counters.
module dram_access_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              proc_done,
  output logic              busy,
  output logic              done,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic              mem_rd_done,
  input  logic              mem_wr_done
`ifdef DRAM_ACCESS_PERF_CNT_EN
  ,
  output logic [15:0]       p0_grant_cnt,
  output logic [15:0]       p1_grant_cnt
`endif
);

  state_e     state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic       wr_done_prev_q;
  logic       arb_en_s;
  logic       rr_mode_s;
  logic [1:0] req_s;
  logic [1:0] gnt_s;

  assign rr_mode_s = (ROUND_ROBIN != 0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD; else state_d = IDLE;
      LOAD:    if (mem_rd_done) state_d = RUN; else state_d = LOAD;
      RUN:     if (proc_done) state_d = DRAIN; else state_d = RUN;
      DRAIN:   state_d = SAVE;
      // Only a fresh 0->1 edge completes the save; a level left high is ignored
      SAVE:    if (mem_wr_done && !wr_done_prev_q) state_d = DONE; else state_d = SAVE;
      DONE:    if (start) state_d = LOAD; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign arb_en_s = (state_q == RUN) && !proc_done;
  assign req_s    = {p1_valid & arb_en_s, p0_valid & arb_en_s};

  rr_arb2 u_arb (
    .req     (req_s),
    .rr_last (rr_last_q),
    .rr_mode (rr_mode_s),
    .gnt     (gnt_s)
  );

  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    rr_last_d = rr_last_q;
    if (gnt_s[0]) begin
      mem_addr  = p0_addr;
      mem_din   = p0_wdata;
      mem_write = p0_we;
      mem_read  = !p0_we;
      rr_last_d = 1'b0;
    end else if (gnt_s[1]) begin
      mem_addr  = p1_addr;
      mem_din   = p1_wdata;
      mem_write = p1_we;
      mem_read  = !p1_we;
      rr_last_d = 1'b1;
    end else begin
      rr_last_d = rr_last_q;
    end
    rd_pend_d = {gnt_s[1] & ~p1_we, gnt_s[0] & ~p0_we};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_last_q      <= 1'b1;
      rd_pend_q      <= 2'b00;
      wr_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_last_q      <= rr_last_d;
      rd_pend_q      <= rd_pend_d;
      wr_done_prev_q <= mem_wr_done;
    end
  end

  assign p0_ready  = gnt_s[0];
  assign p1_ready  = gnt_s[1];
  assign p0_rvalid = rd_pend_q[0];
  assign p1_rvalid = rd_pend_q[1];
  assign p0_rdata  = mem_dout;
  assign p1_rdata  = mem_dout;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign mem_rd_en = (state_q == LOAD);
  assign mem_wr_en = (state_q == SAVE);

`ifdef DRAM_ACCESS_PERF_CNT_EN
  logic [15:0] p0_cnt_q, p0_cnt_d;
  logic [15:0] p1_cnt_q, p1_cnt_d;
  logic        load_entry_s;

  always_comb begin
    load_entry_s = (state_d == LOAD) && (state_q != LOAD);
    p0_cnt_d     = p0_cnt_q;
    p1_cnt_d     = p1_cnt_q;
    if (load_entry_s) begin
      p0_cnt_d = 16'd0;
      p1_cnt_d = 16'd0;
    end else begin
      if (gnt_s[0]) p0_cnt_d = sat_inc16(p0_cnt_q);
      else          p0_cnt_d = p0_cnt_q;
      if (gnt_s[1]) p1_cnt_d = sat_inc16(p1_cnt_q);
      else          p1_cnt_d = p1_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_cnt_q <= 16'd0;
      p1_cnt_q <= 16'd0;
    end else begin
      p0_cnt_q <= p0_cnt_d;
      p1_cnt_q <= p1_cnt_d;
    end
  end

  assign p0_grant_cnt = p0_cnt_q;
  assign p1_grant_cnt = p1_cnt_q;
`endif

endmodule
